// File: rtl/reg_write_arbiter_pkg.sv
// Shared types and widths for the round-robin register-write arbiter.
package reg_arb_pkg;

    // Arbiter FSM: pick a winner, perform its write, then dwell.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WRITE = 2'd1,
        ST_HOLD  = 2'd2
    } state_t;

    // Completed-write counter width (wraps 255 -> 0).
    localparam int CNT_W  = 8;

    // Dwell counter width; covers HOLD_CYCLES up to 15.
    localparam int HOLD_W = 4;

endpackage

// File: rtl/reg_write_arbiter_rr_pick.sv
// Combinational round-robin selector: lowest requesting index at or above
// the pointer wins, wrapping around to index 0.
module rr_pick #(
    parameter int NUM_REQ = 4,
    localparam int IDX_W  = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    output logic               any_req,
    output logic [IDX_W-1:0]   winner
);

    logic found;
    int   idx;

    // Scan NUM_REQ positions starting at ptr; first hit wins.
    always_comb begin
        any_req = |req;
        winner  = '0;
        found   = 1'b0;
        idx     = 0;
        for (int i = 0; i < NUM_REQ; i++) begin
            idx = int'(ptr) + i;
            if (idx >= NUM_REQ) begin
                idx = idx - NUM_REQ;
            end
            if (!found && req[idx]) begin
                found  = 1'b1;
                winner = IDX_W'(idx);
            end
        end
    end

endmodule

// File: rtl/reg_write_arbiter.sv
// Round-robin arbiter sharing one WIDTH-bit register among NUM_REQ
// requesters, with a dwell period after every write.
//
// Handshake: a requester raises req_valid[i] with req_data slice i and holds
// both stable until it sees req_ready[i]; the transfer happens in the single
// cycle where req_valid[i] && req_ready[i], and only then is data sampled.
// Dropping valid before ready withdraws the request with no transfer.
module reg_write_arbiter
    import reg_arb_pkg::*;
#(
    parameter int NUM_REQ     = 4,
    parameter int WIDTH       = 4,
    parameter int HOLD_CYCLES = 2,
    localparam int IDX_W      = $clog2(NUM_REQ)
) (
    input  logic                     clock,
    input  logic                     rst_n,
    input  logic [NUM_REQ-1:0]       req_valid,
    input  logic [NUM_REQ*WIDTH-1:0] req_data,
    output logic [NUM_REQ-1:0]       req_ready,
    output logic [WIDTH-1:0]         q,
    output logic [IDX_W-1:0]         q_owner,
    output logic                     q_changed,
    output logic                     busy,
    output logic [CNT_W-1:0]         wr_count,
    output logic [1:0]               dbg_state
);

    localparam logic [HOLD_W-1:0] HOLD_LAST =
        (HOLD_CYCLES > 0) ? HOLD_W'(HOLD_CYCLES - 1) : '0;
    localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(NUM_REQ - 1);

    state_t             state;
    state_t             state_nxt;
    logic [IDX_W-1:0]   grant_idx;
    logic [IDX_W-1:0]   ptr;
    logic [IDX_W-1:0]   pick_idx;
    logic               any_req;
    logic [HOLD_W-1:0]  hold_cnt;
    logic               wr_fire;
    logic [WIDTH-1:0]   wr_data;

    rr_pick #(
        .NUM_REQ (NUM_REQ)
    ) u_pick (
        .req     (req_valid),
        .ptr     (ptr),
        .any_req (any_req),
        .winner  (pick_idx)
    );

    assign wr_data   = req_data[int'(grant_idx)*WIDTH +: WIDTH];
    assign wr_fire   = (state == ST_WRITE) && req_valid[grant_idx];
    assign busy      = (state != ST_IDLE);
    assign dbg_state = state;

    // Next state and ready decode from the registered state and grant index.
    always_comb begin
        state_nxt = state;
        req_ready = '0;
        case (state)
            ST_IDLE: begin
                if (any_req) begin
                    state_nxt = ST_WRITE;
                end
            end
            ST_WRITE: begin
                if (req_valid[grant_idx]) begin
                    req_ready[grant_idx] = 1'b1;
                    state_nxt = (HOLD_CYCLES == 0) ? ST_IDLE : ST_HOLD;
                end else begin
                    state_nxt = ST_IDLE;
                end
            end
            ST_HOLD: begin
                if (hold_cnt == HOLD_LAST) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // State register, grant capture in IDLE and dwell counter.
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            grant_idx <= '0;
            hold_cnt  <= '0;
        end else begin
            state <= state_nxt;
            if (state == ST_IDLE && any_req) begin
                grant_idx <= pick_idx;
            end
            if (state == ST_HOLD) begin
                hold_cnt <= hold_cnt + HOLD_W'(1);
            end else begin
                hold_cnt <= '0;
            end
        end
    end

    // Shared register, owner, pointer, write counter and change pulse.
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            q         <= '0;
            q_owner   <= '0;
            q_changed <= 1'b0;
            ptr       <= '0;
            wr_count  <= '0;
        end else begin
            q_changed <= 1'b0;
            if (wr_fire) begin
                q         <= wr_data;
                q_owner   <= grant_idx;
                q_changed <= (wr_data != q);
                ptr       <= (grant_idx == LAST_IDX) ? '0 : grant_idx + IDX_W'(1);
                wr_count  <= wr_count + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_reg_write_arbiter.sv
// Bench for reg_write_arbiter at default parameters (4 requesters, 4-bit data,
// 2 dwell cycles).
module tb_reg_write_arbiter;
    import reg_arb_pkg::*;

    localparam int NUM_REQ = 4;
    localparam int WIDTH   = 4;

    // ---------------- clock / reset ----------------
    logic                     clock = 1'b0;
    logic                     rst_n = 1'b0;
    logic [NUM_REQ-1:0]       req_valid = '0;
    logic [NUM_REQ*WIDTH-1:0] req_data  = '0;
    logic [NUM_REQ-1:0]       req_ready;
    logic [WIDTH-1:0]         q;
    logic [1:0]               q_owner;
    logic                     q_changed;
    logic                     busy;
    logic [7:0]               wr_count;
    logic [1:0]               dbg_state;

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    reg_write_arbiter #(
        .NUM_REQ     (NUM_REQ),
        .WIDTH       (WIDTH),
        .HOLD_CYCLES (2)
    ) dut (
        .clock     (clock),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_ready (req_ready),
        .q         (q),
        .q_owner   (q_owner),
        .q_changed (q_changed),
        .busy      (busy),
        .wr_count  (wr_count),
        .dbg_state (dbg_state)
    );

    // ---------------- checking ----------------
    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- scoreboard ----------------
    // Each entry is {owner, data} of a write the driver expects to land.
    logic [5:0] exp_q[$];
    bit         sb_pend = 0;

    initial begin
        logic [5:0] e;
        forever begin
            @(negedge clock);
            if (sb_pend) begin
                if (exp_q.size() == 0) begin
                    check("sb_unexpected_write", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    check("sb_q", q, e[3:0]);
                    check("sb_owner", q_owner, e[5:4]);
                end
                sb_pend = 0;
            end
            if (rst_n && req_ready != 0) sb_pend = 1;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic wait_ready(output bit got, output int lat);
        got = 0;
        lat = -1;
        for (int k = 0; k < 12 && !got; k++) begin
            @(negedge clock);
            if (req_ready != 0) begin
                got = 1;
                lat = k;
            end
        end
        check("ready_seen", got, 1);
    endtask

    task automatic wait_idle();
        bit idle = 0;
        for (int k = 0; k < 20 && !idle; k++) begin
            if (!busy) idle = 1;
            else @(negedge clock);
        end
        check("return_to_idle", idle, 1);
    endtask

    typedef struct {
        logic [3:0]  valid;
        logic [15:0] data;
        logic [1:0]  exp_owner;
        logic [3:0]  exp_q;
        logic        exp_chg;
        logic [7:0]  exp_cnt;
    } vec_t;

    vec_t vecs[9];

    // One arbitration from IDLE: winner's ready one cycle after the request,
    // new q and change pulse the cycle after that.
    task automatic apply_vec(input vec_t v);
        bit got;
        int lat;
        exp_q.push_back({v.exp_owner, v.exp_q});
        @(negedge clock);
        req_valid = v.valid;
        req_data  = v.data;
        wait_ready(got, lat);
        check("ready_latency", lat, 0);
        check("ready_onehot", req_ready, 4'b0001 << v.exp_owner);
        @(posedge clock);
        #1 req_valid = '0;
        @(negedge clock);
        check("q_changed", q_changed, v.exp_chg);
        check("wr_count", wr_count, v.exp_cnt);
        check("busy_in_hold", busy, 1);
        wait_idle();
    endtask

    // ---------------- test sequence ----------------
    initial begin
        bit got;
        int lat;
        int last_cyc;

        vecs[0] = '{4'b0101, 16'h0705, 2'd0, 4'h5, 1'b1, 8'd5};   // wrap after grant 3
        vecs[1] = '{4'b0010, 16'h0010, 2'd1, 4'h1, 1'b1, 8'd6};
        vecs[2] = '{4'b1001, 16'h8002, 2'd3, 4'h8, 1'b1, 8'd7};   // ptr 2: 3 beats 0
        vecs[3] = '{4'b1000, 16'hF000, 2'd3, 4'hF, 1'b1, 8'd8};
        vecs[4] = '{4'b0100, 16'h0F00, 2'd2, 4'hF, 1'b0, 8'd9};   // equal rewrite
        vecs[5] = '{4'b0011, 16'h0043, 2'd0, 4'h3, 1'b1, 8'd10};  // ptr 3 wraps to 0
        vecs[6] = '{4'b0001, 16'h0006, 2'd0, 4'h6, 1'b1, 8'd11};  // leaves ptr at 1
        vecs[7] = '{4'b0110, 16'h09E0, 2'd1, 4'hE, 1'b1, 8'd12};  // after withdraw
        vecs[8] = '{4'b1010, 16'hC010, 2'd1, 4'h1, 1'b1, 8'd1};   // ptr reset to 0

        // Reset state
        repeat (3) @(negedge clock);
        check("rst_q", q, 0);
        check("rst_owner", q_owner, 0);
        check("rst_changed", q_changed, 0);
        check("rst_ready", req_ready, 0);
        check("rst_busy", busy, 0);
        check("rst_count", wr_count, 0);
        check("rst_state", dbg_state, ST_IDLE);
        rst_n = 1'b1;
        repeat (2) @(negedge clock);

        // Contention from pointer 0: grants 0,1,2,3 every 4 cycles
        exp_q.push_back({2'd0, 4'hA});
        exp_q.push_back({2'd1, 4'hB});
        exp_q.push_back({2'd2, 4'hC});
        exp_q.push_back({2'd3, 4'hD});
        req_data  = 16'hDCBA;
        req_valid = 4'b1111;
        last_cyc  = 0;
        for (int g = 0; g < 4; g++) begin
            wait_ready(got, lat);
            check("contend_grant", req_ready, 4'b0001 << g);
            if (g > 0) check("contend_spacing", cyc - last_cyc, 4);
            last_cyc = cyc;
            @(posedge clock);
            #1 req_valid[g] = 1'b0;
        end
        @(negedge clock);
        wait_idle();
        check("contend_count", wr_count, 4);
        check("contend_q", q, 4'hD);

        // Table-driven arbitrations
        for (int i = 0; i < 7; i++) apply_vec(vecs[i]);

        // Withdrawn request: req 1 drops valid in its WRITE cycle
        @(negedge clock);
        req_data  = 16'h0070;
        req_valid = 4'b0010;
        @(posedge clock);
        #1 req_valid = '0;
        @(negedge clock);
        check("wd_state_write", dbg_state, ST_WRITE);
        check("wd_no_ready", req_ready, 0);
        @(negedge clock);
        check("wd_back_idle", dbg_state, ST_IDLE);
        check("wd_q_kept", q, 4'h6);
        check("wd_count_kept", wr_count, 11);
        apply_vec(vecs[7]);   // req 1 still wins over req 2: pointer unchanged

        // Reset asserted mid-HOLD
        exp_q.push_back({2'd2, 4'h5});
        @(negedge clock);
        req_data  = 16'h0500;
        req_valid = 4'b0100;
        wait_ready(got, lat);
        @(posedge clock);
        #1 req_valid = '0;
        @(negedge clock);
        check("pre_rst_state_hold", dbg_state, ST_HOLD);
        check("pre_rst_q", q, 4'h5);
        #2 rst_n = 1'b0;
        #1;
        check("arst_q", q, 0);
        check("arst_owner", q_owner, 0);
        check("arst_changed", q_changed, 0);
        check("arst_busy", busy, 0);
        check("arst_count", wr_count, 0);
        check("arst_ready", req_ready, 0);
        check("arst_state", dbg_state, ST_IDLE);
        repeat (2) @(negedge clock);
        rst_n = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clock);
            check("post_rst_quiet", {busy, req_ready}, 0);
        end
        apply_vec(vecs[8]);

        // Random single requests: one requester, random data
        for (int r = 0; r < 6; r++) begin
            vec_t v;
            int   idx;
            logic [3:0] d;
            idx = $urandom_range(0, 3);
            d   = 4'($urandom_range(0, 15));
            v.valid     = 4'b0001 << idx;
            v.data      = 16'(d) << (idx * 4);
            v.exp_owner = 2'(idx);
            v.exp_chg   = (d != q);
            v.exp_q     = d;
            v.exp_cnt   = 8'(2 + r);
            apply_vec(v);
        end

        repeat (3) @(negedge clock);
        check("sb_drained", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

endmodule

// File: doc/reg_write_arbiter.md
# reg_write_arbiter

Round-robin arbiter that shares one WIDTH-bit data register (the `q <= d` clocked register) among NUM_REQ requesters over valid/ready handshakes. Enforces a minimum dwell time per written value, reports the current owner and flags value changes for the monitor task. Sits between the requester stimulus blocks and the shared register in the test-bench datapath.

## Interface

Parameters:
- NUM_REQ, 4, number of requesters (2..8)
- WIDTH, 4, data register width
- HOLD_CYCLES, 2, dwell cycles after each write before re-arbitration (0..15)

Ports:
- clock  in  1  single clock; all state on posedge clock
- rst_n  in  1  reset, asynchronous assert, active-low
- req_valid  in  NUM_REQ  per-requester write request
- req_data  in  NUM_REQ*WIDTH  requester i data at bits [i*WIDTH +: WIDTH]
- req_ready  out  NUM_REQ  one-hot transfer acknowledge
- q  out  WIDTH  shared register value
- q_owner  out  $clog2(NUM_REQ)  index of the last requester that wrote q
- q_changed  out  1  one-cycle pulse when a write alters q
- busy  out  1  high in WRITE or HOLD
- wr_count  out  8  completed-write counter

## Operation

- Reset values: q=0, q_owner=0, q_changed=0, req_ready=0, busy=0, wr_count=0, rr pointer=0, state IDLE, hold counter 0.
- States:
  - IDLE: if any req_valid, pick the winner by round-robin search starting at the pointer; register its index as grant_idx; go to WRITE. Otherwise stay.
  - WRITE: if req_valid[grant_idx] is still high: req_ready[grant_idx]=1; at the clock edge, q<=req_data slice, q_owner<=grant_idx, pointer<=grant_idx+1 (mod NUM_REQ), wr_count+=1 (wraps 255->0); go to HOLD (or IDLE if HOLD_CYCLES=0). If valid has dropped: no ready, no write, pointer unchanged, go to IDLE.
  - HOLD: count HOLD_CYCLES cycles, then go to IDLE. New requests are ignored (ready stays 0).
- q_changed: registered; high for the one cycle after a write whose data differs from the previous q. Rewriting an equal value counts in wr_count but gives no pulse.
- Handshake: a transfer occurs only in a cycle with valid && ready. Requesters hold valid and data stable until ready. Data is sampled only in the WRITE cycle.
- Simultaneous requests: lowest index at or above the pointer wins, wrapping around. Losers wait with no starvation; worst-case wait is NUM_REQ grants.
- Reset mid-operation: asserting rst_n low clears everything immediately. An in-flight transfer is lost with no ready.

## Timing

- Request seen in IDLE at cycle N -> req_ready high in cycle N+1 -> new q visible from cycle N+2 -> q_changed high in cycle N+2.
- Back-to-back writes: one per 2+HOLD_CYCLES cycles (4 cycles at the default).
- req_ready is registered-state decoded: no combinational path from req_valid to req_ready beyond the grant_idx lookup.
- busy is high in WRITE and HOLD, and low only in IDLE.

## Structure

- Package `reg_arb_pkg`: state enum (IDLE, WRITE, HOLD), counter width constant (8), hold counter width (4).
- Sub-module `rr_pick`: combinational round-robin selector. Inputs are a request vector and a pointer; outputs are any_req and a winner index. Reusable by other arbiters.
- Top level holds the FSM, hold counter, data mux, q/owner/count registers and change detect.

## Test plan

- Reset: drive rst_n=0 mid-HOLD -> all outputs 0 and state IDLE asynchronously. After release, no spurious ready.
- Single requester: req 1 writes 4'h1 -> ready[1] at N+1, q=4'h1 and q_changed=1 at N+2, q_owner=1, wr_count=1.
- Contention: all four valid with data 4'hA, 4'hB, 4'hC, 4'hD from pointer 0 -> grants in order 0,1,2,3. q sequence A,B,C,D at 4-cycle spacing; wr_count=4.
- Pointer wrap: after a grant to req 3, with reqs 0 and 2 valid -> req 0 wins.
- Equal rewrite: q=4'hF, then req 2 writes 4'hF -> ready pulses, wr_count increments, q_changed stays 0, q_owner=2.
- Withdrawn request: req 1 drops valid in its WRITE cycle -> no ready, q unchanged, pointer unchanged, FSM returns to IDLE, and req 1 wins the next arbitration.
